// File: rtl/fsm_cpu.sv
// CPU-side sender of the four-phase send/ack link: streams an incrementing
// DATA_W-bit word to the peripheral, with ack synchronized into clk2.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | reset state, send low; gives data a setup cycle
// REQ     | send high, waiting for synchronized ack to rise
// RELEASE | send low, waiting for synchronized ack to fall
// NEXT    | send low, data advances to the next word
module fsm_cpu #(
  parameter int DATA_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk2,
  input  logic              rst2,
  input  logic              ack,
  output logic              send,
  output logic [DATA_W-1:0] data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_NEXT    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;
  logic                   r_send;
  logic                   w_send_next;
  logic [DATA_W-1:0]      r_data;
  logic [DATA_W-1:0]      w_data_next;

  // ack comes from an unrelated clock domain; only the last stage is used
  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      r_state <= S_IDLE;
      r_send  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_send  <= w_send_next;
      r_data  <= w_data_next;
    end
  end

  // send and data are registered from the next state so they never glitch
  always_comb begin
    w_next      = S_IDLE;
    w_send_next = 1'b0;
    w_data_next = r_data;
    case (r_state)
      S_IDLE:    w_next = S_REQ;
      S_REQ:     w_next = w_ack_s ? S_RELEASE : S_REQ;
      S_RELEASE: w_next = w_ack_s ? S_RELEASE : S_NEXT;
      S_NEXT:    w_next = S_REQ;
      default:   w_next = S_IDLE;
    endcase
    w_send_next = (w_next == S_REQ);
    if (w_next == S_NEXT) begin
      w_data_next = r_data + DATA_W'(1);
    end
  end

  assign send = r_send;
  assign data = r_data;

endmodule

// File: tb/tb_fsm_cpu.sv
// Directed bench for fsm_cpu: reset, handshake latency, slow ack, async reset
// and full word sequences against a behavioral peripheral at several clock ratios.
`timescale 1ns/1ps
module tb_fsm_cpu;
  localparam int DW = 3;

  logic          clk2  = 1'b0;
  logic          clk_p = 1'b0;
  logic          rst2  = 1'b1;
  logic          ack   = 1'b0;
  logic          send;
  logic [DW-1:0] data;

  int hp_cpu = 25;
  int hp_p   = 50;
  int n_vec  = 0;
  int n_err  = 0;
  logic [DW-1:0] sb_q[$];

  fsm_cpu #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk2(clk2),
    .rst2(rst2),
    .ack (ack),
    .send(send),
    .data(data)
  );

  always #(hp_cpu) clk2 = ~clk2;
  initial begin
    #7;
    forever #(hp_p) clk_p = ~clk_p;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_check(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s extra word observed=%0h expected=none", tag, obs);
    end else begin
      e = sb_q.pop_front();
      chk(tag, {29'd0, obs}, {29'd0, e});
    end
  endtask

  // Peripheral: captures data when it sees send high, then completes the handshake
  task automatic peri_run(input int n_words, input int max_cyc, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < n_words && cyc < max_cyc) begin
      @(posedge clk_p);
      cyc++;
      if (send && !ack) begin
        sb_check(tag, data);
        ack = 1'b1;
      end else if (!send && ack) begin
        ack = 1'b0;
        got++;
      end
    end
    if (got < n_words) begin
      n_vec++;
      n_err++;
      $error("FAIL %s timeout words=%0d expected=%0d", tag, got, n_words);
    end
  endtask

  task automatic seq_test(input int hc, input int hpp, input string tag);
    rst2   = 1'b1;
    ack    = 1'b0;
    hp_cpu = hc;
    hp_p   = hpp;
    sb_q.delete();
    repeat (3) @(posedge clk2);
    for (int i = 0; i < 9; i++) sb_q.push_back(DW'(i));
    @(negedge clk2);
    rst2 = 1'b0;
    peri_run(9, 2000, tag);
    chk({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    int w;

    repeat (4) begin
      @(negedge clk2);
      chk("rst_send", {31'd0, send}, 0);
      chk("rst_data", {29'd0, data}, 0);
    end

    @(negedge clk2);
    rst2 = 1'b0;
    @(posedge clk2);
    #1;
    chk("first_send", {31'd0, send}, 1);
    chk("first_data", {29'd0, data}, 0);
    repeat (10) begin
      @(negedge clk2);
      chk("hold_send", {31'd0, send}, 1);
    end

    @(posedge clk2);
    #5 ack = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk2);
      #1;
      chk($sformatf("ack_rise_e%0d", k), {31'd0, send}, (k < 3) ? 1 : 0);
    end

    repeat (20) begin
      @(posedge clk2);
      #1;
      chk("slow_ack_send", {31'd0, send}, 0);
      chk("slow_ack_data", {29'd0, data}, 0);
    end

    @(posedge clk2);
    #5 ack = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk2);
      #1;
      chk($sformatf("ack_fall_e%0d", k), {31'd0, send}, (k < 4) ? 1'b0 : 1'b1);
    end
    chk("second_data", {29'd0, data}, 1);

    @(posedge clk2);
    #10 rst2 = 1'b1;
    #1;
    chk("async_rst_send", {31'd0, send}, 0);
    chk("async_rst_data", {29'd0, data}, 0);
    @(negedge clk2);
    rst2 = 1'b0;
    @(posedge clk2);
    #1;
    chk("restart_send", {31'd0, send}, 1);
    chk("restart_data", {29'd0, data}, 0);

    sb_q.delete();
    for (int i = 0; i < 5; i++) sb_q.push_back(DW'(i));
    peri_run(5, 200, "midop_word");
    w = 0;
    while (!send && w < 20) begin
      @(negedge clk2);
      w++;
    end
    chk("midop_req_send", {31'd0, send}, 1);
    chk("midop_req_data", {29'd0, data}, 5);
    @(posedge clk2);
    #12 rst2 = 1'b1;
    #1;
    chk("midop_rst_send", {31'd0, send}, 0);
    chk("midop_rst_data", {29'd0, data}, 0);
    @(negedge clk2);
    rst2 = 1'b0;
    @(posedge clk2);
    #1;
    chk("midop_restart_send", {31'd0, send}, 1);
    chk("midop_restart_data", {29'd0, data}, 0);

    seq_test(25, 50, "seq_cpu50_p100");
    seq_test(50, 25, "seq_cpu100_p50");
    seq_test(25, 250, "seq_cpu50_p500");
    seq_test(250, 25, "seq_cpu500_p50");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_cpu.md
# fsm_cpu

CPU-side sender of the CPU↔peripheral link. It streams an incrementing 3-bit value to the peripheral receiver (`fsmPeriferico`) over a four-phase send/ack handshake. The peripheral runs on its own, unrelated clock. This block therefore treats `ack` as asynchronous and synchronizes it before any use. It is the only data source on the link.

## Interface
- `DATA_W`, default 3: width of `data`. The link is defined for 3.
- `SYNC_STAGES`, default 2: flip-flop stages in the `ack` synchronizer. Minimum is 2.
- `clk2`  input  1  CPU clock. Rising edge only.
- `rst2`  input  1  one clock; reset is asynchronous and active-high. Assertion forces the reset state immediately. Release takes effect at the next `clk2` rising edge.
- `ack`  input  1  acknowledge from the peripheral, asynchronous to `clk2`. High means the current `data` has been captured.
- `send`  output  DATA-valid request, 1 bit, registered.
- `data`  output  `DATA_W`  payload, registered. Stable whenever `send` is 1.

## Operation
- `ack` passes through a `SYNC_STAGES` flip-flop chain clocked by `clk2`, producing `ack_s`. The FSM uses only `ack_s`.
- Reset state: state = IDLE, `send` = 0, `data` = 0, all synchronizer flops = 0.
- State machine:
  - IDLE: `send` = 0. Unconditionally goes to REQ next cycle. This gives `data` one full cycle of setup before `send` rises.
  - REQ: `send` = 1, `data` held. Stays while `ack_s` = 0. Goes to RELEASE when `ack_s` = 1.
  - RELEASE: `send` = 0, `data` held. Stays while `ack_s` = 1. Goes to NEXT when `ack_s` = 0.
  - NEXT: `send` = 0. `data` <= `data` + 1, modulo 2^`DATA_W` (7 wraps to 0). Goes to REQ.
- Outputs are registered and decoded from the next-state logic, so they never glitch.
- Illegal or unused state encodings return to IDLE on the next edge. In that case `send` = 0 and `data` is held.
- Four-phase contract that the peripheral side must honour:
  - It raises `ack` only after seeing `send` = 1.
  - It drops `ack` only after seeing `send` = 0.
- `ack` already high on entry to REQ (stale ack): treated as an acknowledge. REQ then lasts one cycle. A conforming peripheral never causes this.
- `ack` pulse shorter than the synchronizer can capture: may be missed. In that case `send` stays high until a later `ack` is seen. No data is lost and none is duplicated.
- Reset during any state:
  - Aborts the transfer immediately and asynchronously.
  - `send` drops to 0 without waiting for `ack`.
  - After release, the sequence restarts at `data` = 0.

## Timing
- After `rst2` falls, the 1st `clk2` edge enters REQ with `send` = 1 and `data` = 0. IDLE was the reset state, so there is no separate IDLE cycle after the first edge.
- Ack-rise to send-fall latency, with `SYNC_STAGES` = 2: `ack_s` goes high on the 2nd `clk2` edge after `ack` rises (if setup is met). `send` goes to 0 on the 3rd edge. Worst case is one edge more.
- Ack-fall to next-request latency:
  - `ack_s` goes low 2 edges after `ack` falls.
  - NEXT is entered on the 3rd edge.
  - `send` = 1 with the new `data` on the 4th edge.
- `data` changes only in NEXT, at least one cycle before `send` rises. It never changes while `send` = 1 or during RELEASE.
- With `ack` handshaking as fast as the peripheral allows, throughput is one word per (REQ + RELEASE + NEXT) span. The minimum is 7 `clk2` cycles plus the peripheral's response time.

## Test plan
- Reset values: hold `rst2` = 1 for 200 ns with clocks running → `send` = 0 and `data` = 0 throughout. Assert `rst2` asynchronously between edges → `send` falls within the same cycle.
- First word: release reset with `ack` = 0 → on the 1st edge `send` = 1 and `data` = 0. `send` stays 1 indefinitely while `ack` = 0.
- Handshake latency: raise `ack` 5 ns after an edge → `send` = 0 exactly 3 edges later. Drop `ack` → `data` = 1 and `send` = 1 exactly 4 edges later.
- Full sequence with the real `fsmPeriferico` model:
  - Peripheral clock period 100 ns, CPU clock period 50 ns.
  - Required: `data` = 0,1,…,7,0 in order, with no repeats or skips.
  - Repeat with the clock ratios swapped, and with 10× ratios in both directions.
- Slow ack: hold `ack` = 1 for 20 cycles → `send` = 0 and `data` unchanged for the whole period. No new request until `ack` falls.
- Reset mid-operation: assert `rst2` while in REQ with `data` = 5 → `send` = 0 and `data` = 0 immediately. After release, the sequence restarts at 0.
